// File: rtl/fe_addsub_pipe_if.sv
// fe_addsub_pipe_if -- operand/result bus of the modular add/sub pipeline.
//   master : producer/consumer side (drives operands and i_rdy)
//   slave  : the pipeline (drives o_rdy, o_val, o_dat, o_ctl)
// Signals:
//   i_val/o_rdy            input handshake
//   i_mode, i_a, i_b, i_ctl operation, operands (lane k at [k*DAT_BITS +: DAT_BITS]), tag
//   o_val/i_rdy            output handshake
//   o_dat, o_ctl           result lanes and tag
interface fe_addsub_pipe_if #(
  parameter int DAT_BITS = 256,
  parameter int LANES    = 1,
  parameter int CTL_BITS = 8
);
  logic                      i_val;
  logic                      o_rdy;
  logic [1:0]                i_mode;
  logic [LANES*DAT_BITS-1:0] i_a;
  logic [LANES*DAT_BITS-1:0] i_b;
  logic [CTL_BITS-1:0]       i_ctl;
  logic                      o_val;
  logic                      i_rdy;
  logic [LANES*DAT_BITS-1:0] o_dat;
  logic [CTL_BITS-1:0]       o_ctl;

  modport master (
    output i_val, i_mode, i_a, i_b, i_ctl, i_rdy,
    input  o_rdy, o_val, o_dat, o_ctl
  );

  modport slave (
    input  i_val, i_mode, i_a, i_b, i_ctl, i_rdy,
    output o_rdy, o_val, o_dat, o_ctl
  );
endinterface

// File: rtl/fe_addsub_pipe.sv
// fe_addsub_pipe -- two-stage modular add/sub/neg/dbl over Fp^LANES.
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset
//   bus     : fe_addsub_pipe_if.slave (valid/ready in, valid/ready out)
// Stage 1 forms a DAT_BITS+1 raw value per lane, stage 2 folds it back into
// [0, P-1]. Lanes are independent; one operation per cycle at full rate.

// One lane: raw compute register and corrected result register.
module fe_addsub_lane #(
  parameter int                  DAT_BITS = 256,
  parameter logic [DAT_BITS-1:0] P        = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                s1_ld,
  input  logic                s2_ld,
  input  logic [1:0]          mode,
  input  logic                s1_sub,
  input  logic [DAT_BITS-1:0] a,
  input  logic [DAT_BITS-1:0] b,
  output logic [DAT_BITS-1:0] dat
);
  logic [DAT_BITS:0]   raw_d, raw_q;
  logic [DAT_BITS:0]   minus_p;
  logic [DAT_BITS-1:0] plus_p;
  logic [DAT_BITS-1:0] fix;

  // For sub-like modes the top bit of raw is the borrow.
  always_comb begin
    raw_d = '0;
    unique case (mode)
      2'b00: raw_d = {1'b0, a} + {1'b0, b};
      2'b01: raw_d = {1'b0, a} - {1'b0, b};
      2'b10: raw_d = '0 - {1'b0, a};
      2'b11: raw_d = {a, 1'b0};
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   raw_q <= '0;
    else if (s1_ld) raw_q <= raw_d;
  end

  assign minus_p = raw_q - {1'b0, P};
  assign plus_p  = raw_q[DAT_BITS-1:0] + P;

  // Neg of 0 has no borrow, so it stays 0 rather than becoming P.
  always_comb begin
    fix = raw_q[DAT_BITS-1:0];
    if (s1_sub) begin
      if (raw_q[DAT_BITS]) fix = plus_p;
    end else if (raw_q >= {1'b0, P}) begin
      fix = minus_p[DAT_BITS-1:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   dat <= '0;
    else if (s2_ld) dat <= fix;
  end
endmodule

module fe_addsub_pipe #(
  parameter int                  DAT_BITS = 256,
  parameter logic [DAT_BITS-1:0] P        = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter int                  LANES    = 1,
  parameter int                  CTL_BITS = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  fe_addsub_pipe_if.slave  bus
);
  localparam int STAGES = 2;

  logic [STAGES:1]               vld_pipe;
  logic [STAGES:1]               adv;
  logic                          s1_ld, s2_ld;
  logic                          s1_sub;
  logic [CTL_BITS-1:0]           s1_ctl, s2_ctl;
  logic [LANES-1:0][DAT_BITS-1:0] a_l, b_l, dat_l;

  // Ready ripples back from the output through each stage's valid.
  assign adv[2]    = ~vld_pipe[2] | bus.i_rdy;
  assign adv[1]    = ~vld_pipe[1] | adv[2];
  assign bus.o_rdy = adv[1];

  // Data registers only load on real transfers so bubbles leave them quiet.
  assign s1_ld = adv[1] & bus.i_val;
  assign s2_ld = adv[2] & vld_pipe[1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_pipe <= '0;
      s1_sub   <= 1'b0;
      s1_ctl   <= '0;
      s2_ctl   <= '0;
    end else begin
      if (adv[1]) vld_pipe[1] <= bus.i_val;
      if (adv[2]) vld_pipe[2] <= vld_pipe[1];
      if (s1_ld) begin
        s1_sub <= ^bus.i_mode;  // 01 sub and 10 neg correct by adding P
        s1_ctl <= bus.i_ctl;
      end
      if (s2_ld) s2_ctl <= s1_ctl;
    end
  end

  assign a_l = bus.i_a;
  assign b_l = bus.i_b;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fe_addsub_lane #(.DAT_BITS(DAT_BITS), .P(P)) u_lane (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .s1_ld   (s1_ld),
      .s2_ld   (s2_ld),
      .mode    (bus.i_mode),
      .s1_sub  (s1_sub),
      .a       (a_l[k]),
      .b       (b_l[k]),
      .dat     (dat_l[k])
    );
  end

  assign bus.o_val = vld_pipe[2];
  assign bus.o_dat = dat_l;
  assign bus.o_ctl = s2_ctl;
endmodule

// File: tb/tb_fe_addsub_pipe.sv
// tb_fe_addsub_pipe -- drives an Fp (LANES=1) and an Fp2 (LANES=2) instance in
// lockstep. A modular-arithmetic model fed on every input transfer is compared
// against every output transfer; directed vectors carry literal expectations.
module tb_fe_addsub_pipe;
  localparam int DW = 256;
  localparam int CW = 8;
  localparam logic [DW-1:0] PP = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
  localparam logic [DW-1:0] HP = (PP + 256'd1) >> 1;  // (P+1)/2
  localparam logic [DW-1:0] HM = (PP - 256'd1) >> 1;  // (P-1)/2

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          val = 1'b0, rdy = 1'b1, rand_en = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [DW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [CW-1:0] ctl = '0;

  fe_addsub_pipe_if #(.DAT_BITS(DW), .LANES(1), .CTL_BITS(CW)) if1();
  fe_addsub_pipe_if #(.DAT_BITS(DW), .LANES(2), .CTL_BITS(CW)) if2();

  assign if1.i_val = val;  assign if2.i_val = val;
  assign if1.i_rdy = rdy;  assign if2.i_rdy = rdy;
  assign if1.i_mode = mode; assign if2.i_mode = mode;
  assign if1.i_ctl = ctl;  assign if2.i_ctl = ctl;
  assign if1.i_a = a0;     assign if2.i_a = {a1, a0};
  assign if1.i_b = b0;     assign if2.i_b = {b1, b0};

  fe_addsub_pipe #(.DAT_BITS(DW), .P(PP), .LANES(1), .CTL_BITS(CW)) u_fp (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  fe_addsub_pipe #(.DAT_BITS(DW), .P(PP), .LANES(2), .CTL_BITS(CW)) u_fp2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(if2));

  int n_chk = 0, n_err = 0, outs2 = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Field arithmetic straight from the definition of each mode.
  function automatic logic [DW-1:0] fmod(logic [1:0] m, logic [DW-1:0] x, logic [DW-1:0] y);
    logic [DW+1:0] r;
    case (m)
      2'b00:   r = {2'b0, x} + {2'b0, y};
      2'b01:   r = {2'b0, x} + {2'b0, PP} - {2'b0, y};
      2'b10:   r = {2'b0, PP} - {2'b0, x};
      default: r = {2'b0, x} * 2;
    endcase
    r = r % {2'b0, PP};
    return r[DW-1:0];
  endfunction

  typedef struct {
    logic [DW-1:0] d0, d1;
    logic [CW-1:0] c;
  } exp_t;
  exp_t q1[$], q2[$];

  // Scoreboard: outputs checked before inputs are recorded each cycle.
  initial begin : cmp
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q1.delete();
        q2.delete();
      end else begin
        if (if1.o_val && rdy) begin
          if (q1.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL fp_extra_output: got ctl %h want none", if1.o_ctl);
          end else begin
            e = q1.pop_front();
            chk("fp_dat", if1.o_dat, e.d0);
            chk("fp_ctl", DW'(if1.o_ctl), DW'(e.c));
          end
        end
        if (if2.o_val && rdy) begin
          outs2++;
          if (q2.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL fp2_extra_output: got ctl %h want none", if2.o_ctl);
          end else begin
            e = q2.pop_front();
            chk("fp2_lane0", if2.o_dat[DW-1:0], e.d0);
            chk("fp2_lane1", if2.o_dat[2*DW-1:DW], e.d1);
            chk("fp2_ctl", DW'(if2.o_ctl), DW'(e.c));
          end
        end
        e.d0 = fmod(mode, a0, b0);
        e.d1 = fmod(mode, a1, b1);
        e.c  = ctl;
        if (val && if1.o_rdy) q1.push_back(e);
        if (val && if2.o_rdy) q2.push_back(e);
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_en) rdy = 1'($urandom_range(0, 1));
  end

  // Present one op from posedge+1 until accepted; returns at accept edge + 1.
  task automatic send(logic [1:0] m, logic [DW-1:0] x0, logic [DW-1:0] y0,
                      logic [DW-1:0] x1, logic [DW-1:0] y1, logic [CW-1:0] c);
    bit took = 1'b0;
    int g = 0;
    mode = m; a0 = x0; b0 = y0; a1 = x1; b1 = y1; ctl = c; val = 1'b1;
    while (!took && g < 200) begin
      @(negedge clk);
      took = if1.o_rdy;
      @(posedge clk); #1;
      g++;
    end
    val = 1'b0;
    if (!took) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout: got no o_rdy want o_rdy within 200 cycles");
    end
  endtask

  // Result must appear in the second cycle after the one it was presented in.
  task automatic dir(string nm, logic [1:0] m, logic [DW-1:0] x0, logic [DW-1:0] y0,
                     logic [DW-1:0] x1, logic [DW-1:0] y1, logic [CW-1:0] c,
                     logic [DW-1:0] e0, logic [DW-1:0] e1);
    rdy = 1'b1;
    send(m, x0, y0, x1, y1, c);
    @(negedge clk);
    chk({nm, "_early"}, DW'(if2.o_val), DW'(0));
    @(negedge clk);
    chk({nm, "_val"}, DW'(if2.o_val), DW'(1));
    chk({nm, "_fp"}, if1.o_dat, e0);
    chk({nm, "_l0"}, if2.o_dat[DW-1:0], e0);
    chk({nm, "_l1"}, if2.o_dat[2*DW-1:DW], e1);
    chk({nm, "_ctl"}, DW'(if2.o_ctl), DW'(c));
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_oval", DW'(if2.o_val), DW'(0));
    chk("rst_odat", if2.o_dat[DW-1:0], '0);
    chk("rst_octl", DW'(if2.o_ctl), DW'(0));
    chk("rst_ordy", DW'(if1.o_rdy), DW'(1));
    @(posedge clk); #1;

    dir("add_wrap",  2'b00, PP - 256'd1, 256'd1,      256'd3, 256'd4, 8'h11, 256'd0, 256'd7);
    dir("add_pm2",   2'b00, PP - 256'd1, PP - 256'd1, 256'd0, 256'd0, 8'h12, PP - 256'd2, 256'd0);
    dir("sub_brw",   2'b01, 256'd0, 256'd1, 256'd5, 256'd5, 8'h13, PP - 256'd1, 256'd0);
    dir("sub_eq",    2'b01, 256'd5, 256'd5, 256'd0, 256'd1, 8'h14, 256'd0, PP - 256'd1);
    dir("neg_zero",  2'b10, 256'd0, 256'd9, 256'd1, 256'd0, 8'h15, 256'd0, PP - 256'd1);
    dir("neg_one",   2'b10, 256'd1, 256'd0, 256'd0, 256'd7, 8'h16, PP - 256'd1, 256'd0);
    dir("dbl_hp",    2'b11, HP, 256'd0, HM, 256'd0, 8'h17, 256'd1, PP - 256'd1);
    dir("dbl_hm",    2'b11, HM, 256'd0, HP, 256'd0, 8'h18, PP - 256'd1, 256'd1);
    dir("fp2_indep", 2'b00, PP - 256'd1, 256'd2, 256'd3, 256'd4, 8'hA5, 256'd1, 256'd7);

    // Streaming under random backpressure.
    outs2 = 0;
    rand_en = 1'b1;
    for (int i = 0; i < 20; i++)
      send(2'b00, PP - 256'(i) - 256'd1, 256'(3 * i + 1), 256'(i), PP - 256'd2, CW'(i));
    rand_en = 1'b0;
    @(posedge clk); #2;
    rdy = 1'b1;
    for (int g = 0; g < 100 && (q1.size() != 0 || q2.size() != 0); g++) @(posedge clk);
    #1;
    chk("stream_drain", DW'(q2.size()), DW'(0));
    chk("stream_count", DW'(outs2), DW'(20));

    // Fill both stages with the output stalled.
    rdy = 1'b0;
    send(2'b00, 256'd10, 256'd20, 256'd1, 256'd2, 8'hC1);
    send(2'b00, 256'd11, 256'd21, 256'd1, 256'd3, 8'hC2);
    @(negedge clk);
    chk("full_ordy_fp",  DW'(if1.o_rdy), DW'(0));
    chk("full_ordy_fp2", DW'(if2.o_rdy), DW'(0));
    chk("full_oval", DW'(if2.o_val), DW'(1));
    chk("full_dat",  if2.o_dat[DW-1:0], 256'd30);
    repeat (3) @(negedge clk);
    chk("hold_dat", if2.o_dat[DW-1:0], 256'd30);
    chk("hold_l1",  if2.o_dat[2*DW-1:DW], 256'd3);
    chk("hold_ctl", DW'(if2.o_ctl), DW'(8'hC1));

    // Reset with both stages full.
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_oval", DW'(if2.o_val), DW'(0));
    chk("mrst_odat", if2.o_dat[2*DW-1:DW] | if2.o_dat[DW-1:0], '0);
    chk("mrst_fpdat", if1.o_dat, '0);
    chk("mrst_octl", DW'(if2.o_ctl), DW'(0));
    chk("mrst_ordy", DW'(if2.o_rdy), DW'(1));
    @(posedge clk); #1;
    outs2 = 0;
    rdy = 1'b1;
    send(2'b01, 256'd7, 256'd9, 256'd9, 256'd7, 8'h5A);
    @(negedge clk);
    @(negedge clk);
    chk("post_l0", if2.o_dat[DW-1:0], PP - 256'd2);
    chk("post_l1", if2.o_dat[2*DW-1:DW], 256'd2);
    repeat (8) @(posedge clk);
    #1;
    chk("post_only_one", DW'(outs2), DW'(1));
    chk("post_drain", DW'(q1.size() + q2.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
